// File: rtl/brg_pkg.sv
// Shared types and constants for the USART fractional baud-rate generator.
// BRR layout is mantissa[15:4], fraction[3:0].
package brg_pkg;

    localparam int BRG_MANT_W = 12;
    localparam int BRG_FRAC_W = 4;
    localparam int BRG_MOD16  = 16;
    localparam int BRG_MOD8   = 8;

    typedef struct packed {
        logic [BRG_MANT_W-1:0] mant;
        logic [BRG_FRAC_W-1:0] frac;
    } brr_t;

    // Fraction modulus M: 16 for 16x oversampling, 8 for 8x.
    function automatic logic [BRG_FRAC_W:0] brg_modulus(input logic over8);
        return over8 ? (BRG_FRAC_W+1)'(BRG_MOD8) : (BRG_FRAC_W+1)'(BRG_MOD16);
    endfunction

    // Effective fraction F: bit 3 is ignored in 8x mode.
    function automatic logic [BRG_FRAC_W-1:0] brg_frac(input brr_t brr, input logic over8);
        return over8 ? {1'b0, brr.frac[BRG_FRAC_W-2:0]} : brr.frac;
    endfunction

endpackage

// File: rtl/brg_frac_acc.sv
// Fractional accumulator: adds F once per divided period and reports whether the
// current period must be stretched by one cycle (the accumulator wraps past M).
module brg_frac_acc
    import brg_pkg::*;
(
    input  logic                  i_CLK,
    input  logic                  i_RST_B,
    input  logic [BRG_FRAC_W-1:0] frac,
    input  logic [BRG_FRAC_W:0]   modulus,
    input  logic                  step,
    input  logic                  clear,
    output logic                  carry
);

    logic [BRG_FRAC_W-1:0] acc;
    logic [BRG_FRAC_W:0]   sum;
    logic [BRG_FRAC_W:0]   mod_mask;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, frac};
        carry    = (sum >= modulus);
        mod_mask = modulus - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the reset branch is asynchronous via the sensitivity list.
    always_ff @(posedge i_CLK or posedge i_RST_B) begin
        if (i_RST_B) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            // M is a power of two, so masking is the modulo; it also drops acc[3]
            // when 8x mode is entered with a 16x accumulator value.
            acc <= sum[BRG_FRAC_W-1:0] & mod_mask[BRG_FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_rate_generator.sv
// USART fractional baud-rate divider: emits a one-cycle oversampling tick whose
// average period is USARTDIV = MANT + F/M kernel clock cycles.
module baud_rate_generator
    import brg_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST_B,
    input  logic        i_OVER8,
    input  logic [15:0] i_USARTBRR,
    output logic        o_BRGCLK
);

    brr_t                  brr;
    logic [BRG_MANT_W-1:0] cnt;
    logic                  carry;
    logic                  idle;
    logic                  terminal;
    logic [BRG_MANT_W:0]   period;
    logic [BRG_MANT_W:0]   last_cnt;

    assign brr = brr_t'(i_USARTBRR);

    // Live BRR is compared with >= so a smaller divisor ends the current period at once.
    always_comb begin
        idle     = (brr.mant == '0);
        period   = {1'b0, brr.mant} + {{BRG_MANT_W{1'b0}}, carry};
        last_cnt = period - 1'b1;
        terminal = ({1'b0, cnt} >= last_cnt);
    end

    brg_frac_acc u_frac_acc (
        .i_CLK   (i_CLK),
        .i_RST_B (i_RST_B),
        .frac    (brg_frac(brr, i_OVER8)),
        .modulus (brg_modulus(i_OVER8)),
        .step    (!idle && terminal),
        .clear   (idle),
        .carry   (carry)
    );

    always_ff @(posedge i_CLK or posedge i_RST_B) begin
        if (i_RST_B) begin
            cnt      <= '0;
            o_BRGCLK <= 1'b0;
        end else if (idle) begin
            cnt      <= '0;
            o_BRGCLK <= 1'b0;
        end else if (terminal) begin
            cnt      <= '0;
            o_BRGCLK <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            o_BRGCLK <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator: table of expected tick periods plus
// hand-written sequences for idle, divisor shrink and asynchronous reset.
module tb_baud_rate_generator;
    import brg_pkg::*;

    logic        i_CLK = 1'b0;
    logic        i_RST_B;
    logic        i_OVER8;
    logic [15:0] i_USARTBRR;
    logic        o_BRGCLK;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          rst;
        bit          over8;
        logic [15:0] brr;
        int          period;
        string       name;
    } vec_t;

    vec_t vecs[$];

    baud_rate_generator u_dut (
        .i_CLK      (i_CLK),
        .i_RST_B    (i_RST_B),
        .i_OVER8    (i_OVER8),
        .i_USARTBRR (i_USARTBRR),
        .o_BRGCLK   (o_BRGCLK)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [15:0] mk_brr(input int mant, input int frac);
        brr_t b;
        b.mant = BRG_MANT_W'(mant);
        b.frac = BRG_FRAC_W'(frac);
        return b;
    endfunction

    function automatic void add(input bit rst, input bit over8, input logic [15:0] brr,
                                input int period, input string name);
        vec_t v;
        v.rst = rst; v.over8 = over8; v.brr = brr; v.period = period; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Count rising edges until o_BRGCLK is seen high; -1 if the budget expires.
    task automatic measure(output int edges);
        edges = 0;
        do begin
            @(posedge i_CLK);
            #1;
            edges++;
        end while (o_BRGCLK !== 1'b1 && edges < 400);
        if (o_BRGCLK !== 1'b1) edges = -1;
    endtask

    task automatic apply_reset();
        #2;
        i_RST_B = 1'b1;
        #1;
        check("reset_out_low", int'(o_BRGCLK), 0);
        @(posedge i_CLK);
        #1;
        i_RST_B = 1'b0;
    endtask

    initial begin
        int p;
        int total;
        int hi;

        i_RST_B    = 1'b1;
        i_OVER8    = 1'b0;
        i_USARTBRR = '0;

        // 16x, USARTDIV = 27 + 12/16: pattern 27,28,28,28
        for (int r = 0; r < 2; r++) begin
            add(r == 0, 1'b0, 16'h01BC, 27, "x16_f12_p0");
            add(1'b0,   1'b0, 16'h01BC, 28, "x16_f12_p1");
            add(1'b0,   1'b0, 16'h01BC, 28, "x16_f12_p2");
            add(1'b0,   1'b0, 16'h01BC, 28, "x16_f12_p3");
        end
        // 8x, BRR frac 4'b1100 -> F=4: alternating 27,28
        for (int i = 0; i < 8; i++)
            add(i == 0, 1'b1, mk_brr(27, 12), (i % 2 == 0) ? 27 : 28, "x8_f4");
        // MANT=1, F=0: tick every cycle
        for (int i = 0; i < 4; i++)
            add(i == 0, 1'b0, mk_brr(1, 0), 1, "mant1");
        // MANT=16, F=15: one 16-cycle period then fifteen of 17
        for (int i = 0; i < 16; i++)
            add(i == 0, 1'b0, mk_brr(16, 15), (i == 0) ? 16 : 17, "x16_f15");

        total = 0;
        foreach (vecs[i]) begin
            i_OVER8    = vecs[i].over8;
            i_USARTBRR = vecs[i].brr;
            if (vecs[i].rst) begin
                apply_reset();
                total = 0;
            end
            measure(p);
            check(vecs[i].name, p, vecs[i].period);
            total += p;
            if (vecs[i].name == "x16_f15" && i == vecs.size() - 1)
                check("x16_f15_total", total, 271);
        end

        // Idle divider: MANT=0 holds output low and counter at zero.
        i_OVER8    = 1'b0;
        i_USARTBRR = mk_brr(0, 5);
        apply_reset();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_CLK);
            #1;
            if (o_BRGCLK !== 1'b0 || u_dut.cnt !== '0) hi++;
        end
        check("idle_mant0", hi, 0);

        // Divisor shrink mid-period: 100 -> 10 after 50 cycles.
        i_USARTBRR = mk_brr(100, 0);
        apply_reset();
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_CLK);
            #1;
            if (o_BRGCLK !== 1'b0) hi++;
        end
        check("shrink_no_early_tick", hi, 0);
        i_USARTBRR = mk_brr(10, 0);
        measure(p);
        check("shrink_immediate", p, 1);
        measure(p);
        check("shrink_steady_a", p, 10);
        measure(p);
        check("shrink_steady_b", p, 10);

        // Asynchronous reset while the tick is high, then the pattern restarts.
        i_USARTBRR = 16'h01BC;
        apply_reset();
        measure(p);
        check("async_first", p, 27);
        measure(p);
        check("async_second", p, 28);
        #2;
        i_RST_B = 1'b1;
        #1;
        check("async_drop", int'(o_BRGCLK), 0);
        @(posedge i_CLK);
        #1;
        i_RST_B = 1'b0;
        measure(p);
        check("restart_p0", p, 27);
        measure(p);
        check("restart_p1", p, 28);
        measure(p);
        check("restart_p2", p, 28);
        measure(p);
        check("restart_p3", p, 28);
        measure(p);
        check("restart_p4", p, 27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
